// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, immediate generation, load-use hazard detection.
// Optional macro ID_ILLEGAL_TRAP_EN passes illegal instructions downstream flagged instead of dropping them.

package core;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    typedef enum logic [3:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
        OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM, OP_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        op_class_t   op;
        logic        illegal;
        logic        valid;
    } id_ex_t;

    localparam id_ex_t id_ex_rst = '0;
endpackage

module decode_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         next_rdy,
    input  core::if_id_t if_id,
    output logic [4:0]   rs1_addr,
    output logic [4:0]   rs2_addr,
    input  logic [31:0]  rs1_data,
    input  logic [31:0]  rs2_data,
    input  logic [4:0]   ex_rd,
    input  logic         ex_load,
    input  logic         flush,
    output core::id_ex_t id_ex,
    output logic         rdy,
    output logic [15:0]  stall_cnt
);
    import core::*;

    logic [31:0] w_inst;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
    op_class_t   w_op;
    logic        w_writes, w_use_rs1, w_use_rs2;
    logic        w_illegal, w_illegal_flag, w_hazard, w_load_valid;
    id_ex_t      w_dec;
    id_ex_t      r_id_ex;
    logic [15:0] r_stall_cnt;

    assign w_inst   = if_id.inst;
    assign w_rd     = w_inst[11:7];
    assign rs1_addr = w_inst[19:15];
    assign rs2_addr = w_inst[24:20];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and no latch is inferred.
        w_op      = OP_ILLEGAL;
        w_imm     = '0;
        w_writes  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        unique case (w_inst[6:0])
            7'b0110111: begin w_op = OP_LUI;    w_imm = w_imm_u; w_writes = 1'b1; end
            7'b0010111: begin w_op = OP_AUIPC;  w_imm = w_imm_u; w_writes = 1'b1; end
            7'b1101111: begin w_op = OP_JAL;    w_imm = w_imm_j; w_writes = 1'b1; end
            7'b1100111: begin w_op = OP_JALR;   w_imm = w_imm_i; w_writes = 1'b1; w_use_rs1 = 1'b1; end
            7'b1100011: begin w_op = OP_BRANCH; w_imm = w_imm_b; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            7'b0000011: begin w_op = OP_LOAD;   w_imm = w_imm_i; w_writes = 1'b1; w_use_rs1 = 1'b1; end
            7'b0100011: begin w_op = OP_STORE;  w_imm = w_imm_s; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            7'b0010011: begin w_op = OP_IMM;    w_imm = w_imm_i; w_writes = 1'b1; w_use_rs1 = 1'b1; end
            7'b0110011: begin w_op = OP_OP;     w_writes = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            7'b0001111: begin w_op = OP_FENCE;  w_imm = w_imm_i; end
            7'b1110011: begin w_op = OP_SYSTEM; w_imm = w_imm_i; w_writes = 1'b1; end
            default:    ;
        endcase
    end

    assign w_illegal = (w_op == OP_ILLEGAL);
    assign w_hazard  = if_id.valid && ex_load && (ex_rd != 5'd0) &&
                       ((w_use_rs1 && (rs1_addr == ex_rd)) || (w_use_rs2 && (rs2_addr == ex_rd)));

`ifdef ID_ILLEGAL_TRAP_EN
    assign w_load_valid   = en && if_id.valid;
    assign w_illegal_flag = w_illegal;
`else
    assign w_load_valid   = en && if_id.valid && !w_illegal;
    assign w_illegal_flag = 1'b0;
`endif

    assign w_dec = '{pc: if_id.pc, inst: w_inst, rs1_data: rs1_data, rs2_data: rs2_data,
                     imm: w_imm, rd: w_rd, rd_we: w_writes && (w_rd != 5'd0), op: w_op,
                     illegal: w_illegal_flag, valid: w_load_valid};

    // Flush consumes if_id as well, so fetch may advance even when execute is busy.
    assign rdy = !rst && (flush || (next_rdy && !w_hazard));

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
        if (rst) begin
            r_id_ex     <= id_ex_rst;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_id_ex.valid <= 1'b0;
        end else if (next_rdy) begin
            if (w_hazard) begin
                r_id_ex.valid <= 1'b0;
                if (r_stall_cnt != 16'hFFFF)
                    r_stall_cnt <= r_stall_cnt + 16'd1;
            end else begin
                r_id_ex <= w_dec;
            end
        end
    end

    assign id_ex     = r_id_ex;
    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes model predictions, a monitor pops and compares.
// Honours ID_ILLEGAL_TRAP_EN the same way as the design build.

module tb_decode_stage;
    import core::*;

    logic         clk = 1'b0;
    logic         rst, en, next_rdy;
    if_id_t       if_id;
    logic [4:0]   rs1_addr, rs2_addr;
    logic [31:0]  rs1_data, rs2_data;
    logic [4:0]   ex_rd;
    logic         ex_load, flush;
    id_ex_t       id_ex;
    logic         rdy;
    logic [15:0]  stall_cnt;

    decode_stage dut (
        .clk(clk), .rst(rst), .en(en), .next_rdy(next_rdy), .if_id(if_id),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_rd(ex_rd), .ex_load(ex_load), .flush(flush), .id_ex(id_ex), .rdy(rdy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exp_rdy;
        logic [4:0]  exp_rs1;
        logic [4:0]  exp_rs2;
        id_ex_t      exp_id;
        logic        full;
        logic [15:0] exp_stall;
    } rec_t;

    rec_t   sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    id_ex_t m_id = '0;
    int     m_stall = 0;

    localparam logic [31:0] ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADD  = 32'h001101B3;  // add x3,x2,x1
    localparam logic [31:0] SW   = 32'hFE532E23;  // sw x5,-4(x6)
    localparam logic [31:0] BAD  = 32'hFFFFFFFF;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Opcode rules: class, writes-rd, rs1/rs2 usage, immediate format (0 none, 1 I, 2 S, 3 B, 4 U, 5 J).
    function automatic void classify(input logic [6:0] opc, output op_class_t op,
                                     output logic wr, output logic u1, output logic u2, output int fmt);
        op = OP_ILLEGAL; wr = 1'b0; u1 = 1'b0; u2 = 1'b0; fmt = 0;
        case (opc)
            7'h37: begin op = OP_LUI;    wr = 1'b1; fmt = 4; end
            7'h17: begin op = OP_AUIPC;  wr = 1'b1; fmt = 4; end
            7'h6F: begin op = OP_JAL;    wr = 1'b1; fmt = 5; end
            7'h67: begin op = OP_JALR;   wr = 1'b1; u1 = 1'b1; fmt = 1; end
            7'h63: begin op = OP_BRANCH; u1 = 1'b1; u2 = 1'b1; fmt = 3; end
            7'h03: begin op = OP_LOAD;   wr = 1'b1; u1 = 1'b1; fmt = 1; end
            7'h23: begin op = OP_STORE;  u1 = 1'b1; u2 = 1'b1; fmt = 2; end
            7'h13: begin op = OP_IMM;    wr = 1'b1; u1 = 1'b1; fmt = 1; end
            7'h33: begin op = OP_OP;     wr = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            7'h0F: begin op = OP_FENCE;  fmt = 1; end
            7'h73: begin op = OP_SYSTEM; wr = 1'b1; fmt = 1; end
            default: ;
        endcase
    endfunction

    // Immediates rebuilt with signed integer arithmetic from the encoding's bit weights.
    function automatic logic [31:0] model_imm(input logic [31:0] ins, input int fmt);
        int s;
        s = $signed(ins);
        case (fmt)
            1: return 32'(s >>> 20);
            2: return 32'((s >>> 25) * 32 + int'(ins[11:7]));
            3: return 32'((s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
            4: return ins & 32'hFFFFF000;
            5: return 32'((s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic r, input logic e, input logic nr, input logic v,
                         input logic [31:0] ins, input logic ld, input logic [4:0] erd, input logic fl);
        op_class_t op;
        logic wr, u1, u2, hz;
        int fmt;
        id_ex_t dec;
        rec_t rec;
        @(posedge clk);
        #1;
        rst = r; en = e; next_rdy = nr; flush = fl;
        if_id.valid = v; if_id.inst = ins; if_id.pc = $urandom;
        rs1_data = $urandom; rs2_data = $urandom;
        ex_load = ld; ex_rd = erd;

        classify(ins[6:0], op, wr, u1, u2, fmt);
        dec.pc = if_id.pc; dec.inst = ins; dec.rs1_data = rs1_data; dec.rs2_data = rs2_data;
        dec.imm = model_imm(ins, fmt); dec.rd = ins[11:7]; dec.rd_we = wr && (ins[11:7] != 0); dec.op = op;
`ifdef ID_ILLEGAL_TRAP_EN
        dec.illegal = (op == OP_ILLEGAL);
        dec.valid   = e && v;
`else
        dec.illegal = 1'b0;
        dec.valid   = e && v && (op != OP_ILLEGAL);
`endif
        hz = v && ld && (erd != 0) && ((u1 && ins[19:15] == erd) || (u2 && ins[24:20] == erd));

        rec.exp_rdy = !r && (fl || (nr && !hz));
        rec.exp_rs1 = ins[19:15];
        rec.exp_rs2 = ins[24:20];
        if (r) begin
            m_id = '0; m_stall = 0;
        end else if (fl) begin
            m_id.valid = 1'b0;
        end else if (nr) begin
            if (hz) begin
                m_id.valid = 1'b0;
                if (m_stall < 65535) m_stall++;
            end else begin
                m_id = dec;
            end
        end
        rec.exp_id    = m_id;
        rec.full      = r || m_id.valid;
        rec.exp_stall = 16'(m_stall);
        sb.push_back(rec);
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (sb.size() == 0) continue;
            r = sb[0];
            check("rdy", 256'(rdy), 256'(r.exp_rdy));
            check("rs1_addr", 256'(rs1_addr), 256'(r.exp_rs1));
            check("rs2_addr", 256'(rs2_addr), 256'(r.exp_rs2));
            @(posedge clk);
            #2;
            r = sb.pop_front();
            if (r.full) check("id_ex", 256'(id_ex), 256'(r.exp_id));
            else        check("id_ex.valid", 256'(id_ex.valid), 256'(r.exp_id.valid));
            check("stall_cnt", 256'(stall_cnt), 256'(r.exp_stall));
        end
    end

    initial begin
        logic [6:0]  legal_opc [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] ins;
        int          k;
        rst = 1'b1; en = 1'b0; next_rdy = 1'b0; flush = 1'b0; ex_load = 1'b0; ex_rd = '0;
        if_id = '0; rs1_data = '0; rs2_data = '0;

        drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
        drive(1, 1, 1, 1, ADDI, 1, 1, 1);
        // addi issue, then load-use stall on add and its release
        drive(0, 1, 1, 1, ADDI, 0, 0, 0);
        drive(0, 1, 1, 1, ADD, 1, 2, 0);
        drive(0, 1, 1, 1, ADD, 0, 2, 0);
        // flush wins over hazard and a busy execute stage
        drive(0, 1, 0, 1, ADD, 1, 2, 1);
        // store issue then three held cycles with changing inputs
        drive(0, 1, 1, 1, SW, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 1, ADD, 1, 2, 0);
        drive(0, 1, 1, 1, SW, 0, 0, 0);
        drive(0, 1, 1, 1, BAD, 0, 0, 0);
        drive(0, 1, 1, 1, ADDI, 0, 0, 0);
        drive(0, 0, 1, 1, ADDI, 0, 0, 0);
        // saturate the stall counter and push one hazard past it
        repeat (65536) drive(0, 1, 1, 1, ADD, 1, 2, 0);
        drive(0, 1, 1, 1, ADD, 1, 2, 0);
        // reset in the middle of a stall
        drive(1, 1, 1, 1, ADD, 1, 2, 0);
        drive(0, 1, 1, 1, ADD, 1, 2, 0);
        drive(0, 1, 1, 1, ADD, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            ins = $urandom;
            k = $urandom_range(0, 12);
            ins[6:0]   = (k < 11) ? legal_opc[k] : 7'($urandom);
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive(($urandom_range(0, 99) < 1), ($urandom_range(0, 9) < 9), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 8), ins, ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 1));
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #5;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
